output_bram_drain: RTL and testbench

//  Read-back stage for the 16-bank output BRAM after a 1DCONV/TRANSCONV layer completes.

---
 rtl/drain_pkg.sv | 28 ++
 rtl/drain_fifo.sv | 69 ++++++
 rtl/output_bram_drain.sv | 192 +++++++++++++++++++
 tb/tb_output_bram_drain.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/drain_pkg.sv
// Shared types and helpers for the output BRAM drain: FSM encoding, width
// calculation and lane slicing.
package drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO holding captured BRAM rows (data plus last tag) until the
// downstream consumer accepts them.
module drain_fifo
    import drain_pkg::*;
#(
    parameter int WIDTH = 257,
    parameter int DEPTH = 4,
    localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign push_ok_s = push && (count_r != CNT_W'(DEPTH));
    assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});

    // Row storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign empty    = (count_r == {CNT_W{1'b0}});
    assign full     = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/output_bram_drain.sv
// Sweeps num_rows rows of the output BRAM and streams them out with credit-based
// read issue. Define DRAIN_RELU_EN to clamp negative lanes to zero on output.
module output_bram_drain
    import drain_pkg::*;
#(
    parameter int DW         = 16,
    parameter int NUM_BRAMS  = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [ADDR_WIDTH:0]              num_rows,
    output logic                             busy,
    output logic                             done,
    output logic                             ext_read_mode,
    output logic [NUM_BRAMS*ADDR_WIDTH-1:0]  ext_read_addr_flat,
    input  logic [NUM_BRAMS*DW-1:0]          bram_read_data_flat,
    output logic [NUM_BRAMS*DW-1:0]          m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             m_last
);

    localparam int ROW_W = NUM_BRAMS * DW;
    localparam int CNT_W = clog2(FIFO_DEPTH + 1);

    drain_state_e            state_r;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [ADDR_WIDTH:0]     num_r;
    logic [ADDR_WIDTH:0]     issued_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [RD_LAT:0]         pipe_v_r;
    logic [RD_LAT:0]         pipe_l_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    mode_r;

    logic                    issue_s;
    logic                    issue_last_s;
    logic [ADDR_WIDTH-1:0]   issue_addr_s;
    logic                    pop_s;
    logic                    drained_s;
    int                      inflight_s;
    int                      credits_s;
    logic [ROW_W:0]          fifo_out_s;
    logic [CNT_W-1:0]        fifo_count_s;
    logic                    fifo_empty_s;
    logic                    fifo_full_s;

    assign pop_s = m_valid && m_ready;

    // Pipe stage 0 is the address on the bus; stage RD_LAT is the capture cycle
    always_comb begin
        inflight_s = 0;
        for (int k = 0; k <= RD_LAT; k++) begin
            inflight_s = inflight_s + {31'd0, pipe_v_r[k]};
        end
        credits_s = FIFO_DEPTH - int'(fifo_count_s) - inflight_s + (pop_s ? 32'sd1 : 32'sd0);
        drained_s = (pipe_v_r == {(RD_LAT+1){1'b0}}) &&
                    ((fifo_count_s == {CNT_W{1'b0}}) || ((fifo_count_s == CNT_W'(1)) && pop_s));
    end

    // Read issue decision: first row on the accepted start, then one per credit
    always_comb begin
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        issue_addr_s = addr_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (num_rows != {(ADDR_WIDTH+1){1'b0}})) begin
                    issue_s      = 1'b1;
                    issue_last_s = (num_rows == (ADDR_WIDTH+1)'(1));
                    issue_addr_s = base_addr;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_ISSUE: begin
                if ((credits_s > 32'sd0) && !fifo_full_s) begin
                    issue_s      = 1'b1;
                    issue_last_s = ((issued_r + (ADDR_WIDTH+1)'(1)) == num_r);
                    issue_addr_s = base_r + issued_r[ADDR_WIDTH-1:0];
                end else begin
                    issue_s = 1'b0;
                end
            end
            default: issue_s = 1'b0;
        endcase
    end

    // Control FSM, address register, capture pipe and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            base_r   <= {ADDR_WIDTH{1'b0}};
            num_r    <= {(ADDR_WIDTH+1){1'b0}};
            issued_r <= {(ADDR_WIDTH+1){1'b0}};
            addr_r   <= {ADDR_WIDTH{1'b0}};
            pipe_v_r <= {(RD_LAT+1){1'b0}};
            pipe_l_r <= {(RD_LAT+1){1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            mode_r   <= 1'b0;
        end else begin
            pipe_v_r <= {pipe_v_r[RD_LAT-1:0], issue_s};
            pipe_l_r <= {pipe_l_r[RD_LAT-1:0], issue_last_s};
            done_r   <= 1'b0;
            if (issue_s) begin
                addr_r <= issue_addr_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        base_r <= base_addr;
                        num_r  <= num_rows;
                        busy_r <= 1'b1;
                        if (num_rows == {(ADDR_WIDTH+1){1'b0}}) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            issued_r <= (ADDR_WIDTH+1)'(1);
                            mode_r   <= 1'b1;
                            state_r  <= issue_last_s ? ST_FLUSH : ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (issue_s) begin
                        issued_r <= issued_r + (ADDR_WIDTH+1)'(1);
                        if (issue_last_s) begin
                            state_r <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (drained_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        mode_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    mode_r  <= 1'b0;
                end
            endcase
        end
    end

    drain_fifo #(
        .WIDTH (ROW_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_v_r[RD_LAT]),
        .push_data ({pipe_l_r[RD_LAT], bram_read_data_flat}),
        .pop       (pop_s),
        .pop_data  (fifo_out_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    assign busy          = busy_r;
    assign done          = done_r;
    assign ext_read_mode = mode_r;
    assign m_valid       = !fifo_empty_s;
    assign m_last        = fifo_out_s[ROW_W] && m_valid;

    for (genvar i = 0; i < NUM_BRAMS; i++) begin : g_lane
        localparam int LSB = lane_lsb(i, DW);
        logic [DW-1:0] raw_s;
        assign raw_s = m_valid ? fifo_out_s[LSB +: DW] : {DW{1'b0}};
`ifdef DRAIN_RELU_EN
        assign m_data[LSB +: DW] = raw_s[DW-1] ? {DW{1'b0}} : raw_s;
`else
        assign m_data[LSB +: DW] = raw_s;
`endif
        assign ext_read_addr_flat[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_r;
    end

endmodule

// File: tb/tb_output_bram_drain.sv
// Scoreboard bench for output_bram_drain: a behavioural BRAM with per-bank
// addressing, expected rows queued at start, and a monitor popping on each beat.
`timescale 1ns/1ps
module tb_output_bram_drain;

    localparam int DW = 16, NB = 16, AW = 10, RD_LAT = 2, FD = 4;
    localparam int RW = NB * DW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW:0]       num_rows = '0;
    logic              m_ready = 1'b1;
    logic              busy, done, ext_read_mode, m_valid, m_last;
    logic [NB*AW-1:0]  ext_read_addr_flat;
    logic [RW-1:0]     bram_read_data_flat;
    logic [RW-1:0]     m_data;

    output_bram_drain #(
        .DW(DW), .NUM_BRAMS(NB), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .busy(busy), .done(done), .ext_read_mode(ext_read_mode),
        .ext_read_addr_flat(ext_read_addr_flat), .bram_read_data_flat(bram_read_data_flat),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BRAM: each bank reads at its own address, RD_LAT cycles of latency
    logic [RW-1:0] bram [1024];
    logic [RW-1:0] rd_pipe [RD_LAT];
    logic [RW-1:0] rd_row;
    always @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            rd_row[i*DW +: DW] = ext_read_mode ? bram[ext_read_addr_flat[i*AW +: AW]][i*DW +: DW] : '0;
        end
        rd_pipe[0] <= rd_row;
        for (int j = 1; j < RD_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign bram_read_data_flat = rd_pipe[RD_LAT-1];

    typedef struct packed {
        logic [RW-1:0] data;
        logic          last;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [RW-1:0] model_row(input logic [RW-1:0] r);
        logic [RW-1:0] o;
        o = r;
`ifdef DRAIN_RELU_EN
        for (int i = 0; i < NB; i++) begin
            if ($signed(r[i*DW +: DW]) < 0) o[i*DW +: DW] = '0;
        end
`endif
        return o;
    endfunction

    task automatic push_expected(input int base, input int rows);
        exp_t x;
        for (int k = 0; k < rows; k++) begin
            x.data = model_row(bram[(base + k) % 1024]);
            x.last = (k == rows - 1);
            exp_q.push_back(x);
        end
    endtask

    // Monitor state (written only by the monitor process)
    int  t0 = 0, beats = 0, first_valid_rel = -1, last_beat_rel = -1, done_rel = -1;
    int  done_cnt = 0, issued = 0, max_out = 0;
    bit  mode_seen = 0, prev_mode = 0, hold_pending = 0;
    logic [AW-1:0] prev_addr = '0;

    // Monitor: samples on the falling edge, pops and compares on each transfer
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 0;
                prev_mode = 0;
            end else begin
                if (start && !busy) begin
                    t0 = cyc; beats = 0; first_valid_rel = -1; last_beat_rel = -1;
                    done_rel = -1; done_cnt = 0; mode_seen = 0; issued = 0; max_out = 0;
                end
                if (hold_pending) begin
                    check("valid_held_under_stall", m_valid, 1);
                    hold_pending = 0;
                end
                if (ext_read_mode) begin
                    mode_seen = 1;
                    if (!prev_mode || ext_read_addr_flat[AW-1:0] != prev_addr) issued++;
                end
                if (issued - beats > max_out) max_out = issued - beats;
                prev_mode = ext_read_mode;
                prev_addr = ext_read_addr_flat[AW-1:0];
                if (done) begin
                    done_cnt++;
                    done_rel = cyc - t0;
                end
                if (m_valid) begin
                    if (first_valid_rel < 0) first_valid_rel = cyc - t0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_beat: actual m_valid=1 required no beat (t=%0t)", $time);
                    end else if (m_ready) begin
                        e = exp_q.pop_front();
                        check("beat_data", m_data, e.data);
                        check("beat_last", m_last, e.last);
                    end else begin
                        check("stalled_data", m_data, exp_q[0].data);
                        hold_pending = 1;
                    end
                    if (m_ready) begin
                        beats++;
                        last_beat_rel = cyc - t0;
                    end
                end
            end
        end
    end

    function automatic logic ready_for(input int mode, input int rel);
        if (mode == 0) return 1'b1;
        if (mode == 1) return !(rel >= 3 && rel <= 14);
        return ($urandom_range(0, 9) < 7);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ext_read_mode"}, ext_read_mode, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_addr_flat"}, ext_read_addr_flat, 0);
    endtask

    task automatic run_drain(input int base, input int rows, input int mode, input bit spurious);
        int rel, budget;
        bit finished;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = AW'(base);
        num_rows = (AW+1)'(rows);
        m_ready = ready_for(mode, 0);
        push_expected(base, rows);
        @(posedge clk); #1;
        start = 1'b0;
        rel = 1;
        budget = rows * 6 + 60;
        finished = 0;
        while (!finished && rel < budget) begin
            m_ready = ready_for(mode, rel);
            if (spurious && busy && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                base_addr = AW'($urandom);
                num_rows = (AW+1)'($urandom_range(1, 20));
            end
            @(posedge clk); #1;
            start = 1'b0;
            rel++;
            if (done_cnt > 0 && !busy) finished = 1;
        end
        if (!finished) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: actual unfinished after %0d cycles required done (base=%0d rows=%0d)", rel, base, rows);
        end
        m_ready = 1'b1;
        check("beat_count", beats, rows);
        check("queue_empty", exp_q.size(), 0);
        check("done_pulses", done_cnt, 1);
        check("busy_after", busy, 0);
        check("read_mode_after", ext_read_mode, 0);
        check("outstanding_le_depth", (max_out <= FD), 1);
        if (rows > 0) begin
            check("first_valid_cycle", first_valid_rel, 2 + RD_LAT);
            check("done_after_last_beat", done_rel, last_beat_rel + 1);
        end else begin
            check("zero_rows_done_cycle", done_rel, 1);
            check("zero_rows_read_mode", mode_seen, 0);
            check("zero_rows_no_valid", first_valid_rel, -1);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 1024; k++) begin
            for (int i = 0; i < NB; i++) bram[k][i*DW +: DW] = DW'($urandom);
        end
    endtask

    initial begin
        logic [RW-1:0] row;
        int guard;
        for (int k = 0; k < 1024; k++) begin
            for (int i = 0; i < NB; i++) row[i*DW +: DW] = DW'(k * 16 + i);
            bram[k] = row;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_drain(0, 4, 0, 0);
        run_drain(100, 8, 1, 0);

        fill_random();
        run_drain(1022, 4, 0, 0);
        run_drain(7, 0, 0, 0);

        // Reset in the middle of an 8-row drain
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(200); num_rows = (AW+1)'(8); m_ready = 1'b1;
        push_expected(200, 8);
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (beats < 3 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("mid_drain_reached_3_beats", (guard < 50), 1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        run_drain(5, 2, 0, 0);

        // Signed lanes for the optional clamp
        row = bram[300];
        row[0 +: DW]  = -16'sd5;
        row[DW +: DW] = 16'sd0;
        row[2*DW +: DW] = 16'sd7;
        bram[300] = row;
        run_drain(300, 1, 0, 0);

        run_drain(1023, 1, 2, 0);
        for (int n = 0; n < 6; n++) begin
            run_drain($urandom_range(0, 1023), $urandom_range(1, 40), 2, 1);
        end
        run_drain($urandom_range(0, 1023), 1024, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
